// File: rtl/rtc_timer_bank.sv
// Bank of independent up-counting timer channels with per-channel prescaler,
// clock or 1 Hz count source, one-shot / retrigger / free-running compare modes.
module rtc_timer_bank #(
  parameter int N_TIMERS        = 4,
  parameter int TIMER_WIDTH     = 17,
  parameter int PRESCALER_WIDTH = 8,
  parameter int SEC_CNT_WIDTH   = 15,
  localparam int CH_W           = (N_TIMERS > 1) ? $clog2(N_TIMERS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            sec_sync_i,
  input  logic [9:0]                      sec_init_i,
  output logic                            sec_tick_o,
  input  logic                            cfg_update_i,
  input  logic [CH_W-1:0]                 cfg_ch_i,
  input  logic                            cfg_enable_i,
  input  logic [1:0]                      cfg_mode_i,
  input  logic                            cfg_src_i,
  input  logic [PRESCALER_WIDTH-1:0]      cfg_prescale_i,
  input  logic [TIMER_WIDTH-1:0]          cfg_target_i,
  input  logic [N_TIMERS-1:0]             irq_mask_i,
  input  logic [N_TIMERS-1:0]             pending_clr_i,
  output logic [N_TIMERS*TIMER_WIDTH-1:0] value_o,
  output logic [N_TIMERS-1:0]             running_o,
  output logic [N_TIMERS-1:0]             event_o,
  output logic [N_TIMERS-1:0]             pending_o,
  output logic                            irq_o
);

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RETRIG  = 2'b01,
    MODE_FREE    = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  // Shared sub-second counter; its all-ones state is the 1 Hz tick.
  logic [SEC_CNT_WIDTH-1:0] sec_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sec_cnt_q <= '0;
    end else if (sec_sync_i) begin
      sec_cnt_q <= {sec_init_i, {(SEC_CNT_WIDTH-10){1'b0}}};
    end else begin
      sec_cnt_q <= sec_cnt_q + SEC_CNT_WIDTH'(1);
    end
  end

  assign sec_tick_o = (sec_cnt_q == {SEC_CNT_WIDTH{1'b1}}) && !sec_sync_i;

  // cfg_update_i is a single-cycle write strobe with no back-pressure: the
  // addressed channel takes the new configuration on the next edge.
  for (genvar k = 0; k < N_TIMERS; k++) begin : g_ch
    logic                       running_q;
    mode_e                      mode_q;
    logic                       src_q;
    logic [PRESCALER_WIDTH-1:0] presc_q;
    logic [PRESCALER_WIDTH-1:0] presc_cnt_q;
    logic [TIMER_WIDTH-1:0]     target_q;
    logic [TIMER_WIDTH-1:0]     value_q;
    logic                       event_q;
    logic                       pending_q;

    logic upd, src_evt, tick, match, is_free, is_oneshot, evt_set;

    assign upd        = cfg_update_i && (cfg_ch_i == CH_W'(k));
    assign src_evt    = src_q ? sec_tick_o : 1'b1;
    assign tick       = running_q && src_evt && (presc_cnt_q == presc_q);
    assign match      = (value_q == target_q);
    assign is_free    = (mode_q == MODE_FREE);
    assign is_oneshot = (mode_q != MODE_RETRIG) && !is_free;
    // A tick coinciding with a reconfiguration of this channel is dropped.
    assign evt_set    = tick && match && !upd;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        running_q   <= 1'b0;
        mode_q      <= MODE_ONESHOT;
        src_q       <= 1'b0;
        presc_q     <= '0;
        presc_cnt_q <= '0;
        target_q    <= '0;
        value_q     <= '0;
        event_q     <= 1'b0;
      end else if (upd) begin
        running_q   <= cfg_enable_i;
        mode_q      <= mode_e'(cfg_mode_i);
        src_q       <= cfg_src_i;
        presc_q     <= cfg_prescale_i;
        presc_cnt_q <= '0;
        target_q    <= cfg_target_i;
        value_q     <= '0;
        event_q     <= 1'b0;
      end else begin
        event_q <= evt_set;
        if (running_q && src_evt) begin
          if (presc_cnt_q == presc_q) presc_cnt_q <= '0;
          else                        presc_cnt_q <= presc_cnt_q + PRESCALER_WIDTH'(1);
        end
        if (tick) begin
          if (is_free || !match) begin
            value_q <= value_q + TIMER_WIDTH'(1);
          end else begin
            value_q <= '0;
            if (is_oneshot) running_q <= 1'b0;
          end
        end
      end
    end

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk_i) begin
      if (rst_i) pending_q <= 1'b0;
      else       pending_q <= (pending_q && !pending_clr_i[k]) || evt_set;
    end

    assign value_o[k*TIMER_WIDTH +: TIMER_WIDTH] = value_q;
    assign running_o[k] = running_q;
    assign event_o[k]   = event_q;
    assign pending_o[k] = pending_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= |(pending_o & irq_mask_i);
  end

endmodule

// File: tb/tb_rtc_timer_bank.sv
// Directed bench for rtc_timer_bank; a narrower counter keeps the
// free-running wrap test short.
module tb_rtc_timer_bank;
  localparam int N  = 4;
  localparam int TW = 12;
  localparam int PW = 8;
  localparam int SW = 15;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            sec_sync_i;
  logic [9:0]      sec_init_i;
  logic            sec_tick_o;
  logic            cfg_update_i;
  logic [1:0]      cfg_ch_i;
  logic            cfg_enable_i;
  logic [1:0]      cfg_mode_i;
  logic            cfg_src_i;
  logic [PW-1:0]   cfg_prescale_i;
  logic [TW-1:0]   cfg_target_i;
  logic [N-1:0]    irq_mask_i;
  logic [N-1:0]    pending_clr_i;
  logic [N*TW-1:0] value_o;
  logic [N-1:0]    running_o;
  logic [N-1:0]    event_o;
  logic [N-1:0]    pending_o;
  logic            irq_o;

  rtc_timer_bank #(
    .N_TIMERS(N), .TIMER_WIDTH(TW), .PRESCALER_WIDTH(PW), .SEC_CNT_WIDTH(SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sec_sync_i(sec_sync_i), .sec_init_i(sec_init_i),
    .sec_tick_o(sec_tick_o), .cfg_update_i(cfg_update_i), .cfg_ch_i(cfg_ch_i),
    .cfg_enable_i(cfg_enable_i), .cfg_mode_i(cfg_mode_i), .cfg_src_i(cfg_src_i),
    .cfg_prescale_i(cfg_prescale_i), .cfg_target_i(cfg_target_i),
    .irq_mask_i(irq_mask_i), .pending_clr_i(pending_clr_i), .value_o(value_o),
    .running_o(running_o), .event_o(event_o), .pending_o(pending_o), .irq_o(irq_o)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
  endtask

  function automatic logic [TW-1:0] val(input int k);
    return value_o[k*TW +: TW];
  endfunction

  // Driver: one update strobe; returns in the cycle after the update cycle.
  task automatic cfg(input int ch, input logic en, input logic [1:0] mode, input logic src,
                     input logic [PW-1:0] presc, input logic [TW-1:0] tgt);
    cfg_update_i   = 1'b1;
    cfg_ch_i       = 2'(ch);
    cfg_enable_i   = en;
    cfg_mode_i     = mode;
    cfg_src_i      = src;
    cfg_prescale_i = presc;
    cfg_target_i   = tgt;
    step(1);
    cfg_update_i   = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    rst_i = 1'b1; sec_sync_i = 1'b0; sec_init_i = '0; cfg_update_i = 1'b0;
    cfg_ch_i = '0; cfg_enable_i = 1'b0; cfg_mode_i = '0; cfg_src_i = 1'b0;
    cfg_prescale_i = '0; cfg_target_i = '0; irq_mask_i = '0; pending_clr_i = '0;
    step(2);
    check("rst_value", value_o, 0);
    check("rst_running", running_o, 0);
    check("rst_event", event_o, 0);
    check("rst_pending", pending_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_sec_tick", sec_tick_o, 0);
    rst_i = 1'b0;

    // One-shot, target 5: event 7 cycles after the update cycle
    cfg(0, 1'b1, 2'b00, 1'b0, 0, 5);
    check("a_run", running_o[0], 1);
    check("a_val0", val(0), 0);
    step(5);
    check("a_val5", val(0), 5);
    check("a_noevt", event_o[0], 0);
    step(1);
    check("a_evt", event_o[0], 1);
    check("a_pend", pending_o[0], 1);
    check("a_val_clr", val(0), 0);
    check("a_stop", running_o[0], 0);
    n = 0;
    repeat (6) begin step(1); n += int'(event_o[0]); end
    check("a_once", n, 0);
    check("a_hold", val(0), 0);

    // Retrigger, prescale 3, target 2: event every 12 cycles
    cfg(1, 1'b1, 2'b01, 1'b0, 3, 2);
    base = cyc - 1;
    exp_q.push_back(32'(base + 13));
    exp_q.push_back(32'(base + 25));
    exp_q.push_back(32'(base + 37));
    for (int rel = 1; rel <= 40; rel++) begin
      if (event_o[1]) begin
        if (exp_q.size() == 0) check("b_extra_evt", rel, 0);
        else                   check("b_evt_cyc", cyc, exp_q.pop_front());
      end
      if (rel == 37) check("b_pend_setwins", pending_o[1], 1);
      if (rel == 39) check("b_pend_clr", pending_o[1], 0);
      pending_clr_i = (rel == 36 || rel == 38) ? 4'b0010 : 4'b0000;
      step(1);
    end
    pending_clr_i = '0;
    check("b_evt_left", exp_q.size(), 0);
    cfg(1, 1'b0, 2'b00, 1'b0, 0, 0);
    check("b_stopped", running_o[1], 0);

    // Masked interrupt lags pending by one cycle
    irq_mask_i = 4'b0010;
    cfg(1, 1'b1, 2'b00, 1'b0, 0, 0);
    check("c_irq_pre", irq_o, 0);
    step(1);
    check("c_pend", pending_o, 4'b0011);
    check("c_irq_lag", irq_o, 0);
    step(1);
    check("c_irq_set", irq_o, 1);
    check("c_tgt0_stop", running_o[1], 0);
    pending_clr_i = 4'b0010;
    step(1);
    pending_clr_i = '0;
    check("c_pend_clr", pending_o, 4'b0001);
    check("c_irq_hold", irq_o, 1);
    step(1);
    check("c_irq_drop", irq_o, 0);

    // Free-running wrap at all-ones target
    cfg(2, 1'b1, 2'b10, 1'b0, 0, 12'hFFF);
    step(4094);
    check("d_val_fffe", val(2), 12'hFFE);
    check("d_noevt", event_o[2], 0);
    step(1);
    check("d_val_ffff", val(2), 12'hFFF);
    step(1);
    check("d_wrap", val(2), 0);
    check("d_evt", event_o[2], 1);
    check("d_running", running_o[2], 1);
    step(1);
    check("d_val1", val(2), 1);
    check("d_evt_end", event_o[2], 0);
    cfg(2, 1'b0, 2'b00, 1'b0, 0, 0);

    // Seconds tick after sync, ch3 one-shot on the second tick
    cfg(3, 1'b1, 2'b00, 1'b1, 0, 1);
    sec_sync_i = 1'b1; sec_init_i = 10'h3FF;
    step(1);
    sec_sync_i = 1'b0;
    step(30);
    check("e_no_tick", sec_tick_o, 0);
    check("e_ch3_wait", val(3), 0);
    step(1);
    check("e_tick1", sec_tick_o, 1);
    step(1);
    check("e_tick_end", sec_tick_o, 0);
    check("e_ch3_val1", val(3), 1);
    check("e_ch3_noevt", event_o[3], 0);
    sec_sync_i = 1'b1;
    step(1);
    sec_sync_i = 1'b0;
    step(31);
    check("e_tick2", sec_tick_o, 1);
    step(1);
    check("e_ch3_evt", event_o[3], 1);
    check("e_ch3_stop", running_o[3], 0);
    check("e_ch3_pend", pending_o[3], 1);

    // Update on the matching tick discards the event
    pending_clr_i = 4'hF;
    step(1);
    pending_clr_i = '0;
    check("f_pend_clr", pending_o, 0);
    cfg(1, 1'b1, 2'b01, 1'b0, 0, 9);
    cfg(0, 1'b1, 2'b00, 1'b0, 0, 3);
    step(3);
    check("f_val3", val(0), 3);
    cfg(0, 1'b1, 2'b00, 1'b0, 0, 3);
    check("f_no_evt", event_o[0], 0);
    check("f_val0", val(0), 0);
    check("f_no_pend", pending_o[0], 0);
    check("f_ch1_val", val(1), 5);

    // Reset mid-count drops the pending event pulse of ch1
    step(4);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    check("g_value", value_o, 0);
    check("g_running", running_o, 0);
    check("g_event", event_o, 0);
    check("g_pending", pending_o, 0);
    check("g_irq", irq_o, 0);
    step(5);
    check("g_idle_val", value_o, 0);
    check("g_idle_evt", event_o, 0);
    cfg(0, 1'b1, 2'b00, 1'b0, 0, 2);
    step(2);
    check("g_val2", val(0), 2);
    check("g_noevt", event_o[0], 0);
    step(1);
    check("g_evt", event_o[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
